// File: rtl/updown_mod_counter.sv
// Parametrised modulo up/down counter with prescaler, wrap/saturate mode and status flags.
// Shared timebase/event counter: clr > load > en priority, one-cycle wrap pulse.
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MOD      = 256,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    // Top of range held in WIDTH bits so MOD == 2**WIDTH never needs a wider constant.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam int unsigned      PSC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [WIDTH-1:0] cnt_nxt;
    logic [PSC_W-1:0] psc;
    logic [PSC_W-1:0] psc_nxt;
    logic             wrap_nxt;

    // Next-state: priority clr > load > en; wrap defaults low so it only pulses.
    always_comb begin
        cnt_nxt  = cnt;
        psc_nxt  = psc;
        wrap_nxt = 1'b0;
        if (clr) begin
            cnt_nxt = '0;
            psc_nxt = '0;
        end else if (load) begin
            cnt_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            psc_nxt = '0;
        end else if (en) begin
            if (psc != PSC_LAST) begin
                psc_nxt = psc + PSC_W'(1);
            end else begin
                psc_nxt = '0;
                if (up) begin
                    if (cnt == MAX_VAL) begin
                        if (SATURATE == 0) begin
                            cnt_nxt  = '0;
                            wrap_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + WIDTH'(1);
                    end
                end else begin
                    if (cnt == '0) begin
                        if (SATURATE == 0) begin
                            cnt_nxt  = MAX_VAL;
                            wrap_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt - WIDTH'(1);
                    end
                end
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            psc  <= '0;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            psc  <= psc_nxt;
            wrap <= wrap_nxt;
        end
    end

    assign at_max = (cnt == MAX_VAL);
    assign at_min = (cnt == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: four counter configurations driven by shared stimulus,
// a vector table, directed corner sequences and random traffic against an arithmetic model.
`timescale 1ns/1ps
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr, load, en, up;
    logic [7:0] lv;
    logic [3:0] lv4;

    logic [3:0] cnt_w, cnt_s, cnt_p;
    logic [7:0] cnt_f;
    logic       wrap_w, wrap_s, wrap_p, wrap_f;
    logic       amax_w, amax_s, amax_p, amax_f;
    logic       amin_w, amin_s, amin_p, amin_f;

    int n_cmp = 0;
    int n_bad = 0;

    // Model configuration per instance: 0 wrap, 1 saturate, 2 prescale 3, 3 full 8-bit range.
    int mods[4]  = '{10, 10, 10, 256};
    int sats[4]  = '{0, 1, 0, 0};
    int pres[4]  = '{1, 1, 3, 1};
    int masks[4] = '{15, 15, 15, 255};
    int m_cnt[4];
    int m_psc[4];
    int m_wrap[4];

    assign lv4 = lv[3:0];

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(0), .PRESCALE(1)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv4), .en(en), .up(up),
        .cnt(cnt_w), .wrap(wrap_w), .at_max(amax_w), .at_min(amin_w));
    updown_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(1), .PRESCALE(1)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv4), .en(en), .up(up),
        .cnt(cnt_s), .wrap(wrap_s), .at_max(amax_s), .at_min(amin_s));
    updown_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(0), .PRESCALE(3)) u_psc (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv4), .en(en), .up(up),
        .cnt(cnt_p), .wrap(wrap_p), .at_max(amax_p), .at_min(amin_p));
    updown_mod_counter #(.WIDTH(8), .MOD(256), .SATURATE(0), .PRESCALE(1)) u_full (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv), .en(en), .up(up),
        .cnt(cnt_f), .wrap(wrap_f), .at_max(amax_f), .at_min(amin_f));

    typedef struct {
        logic       clr;
        logic       load;
        logic [7:0] lv;
        logic       en;
        logic       up;
        int         exp_cnt;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic get(input int idx, output logic [31:0] c, output logic w, output logic mx, output logic mn);
        case (idx)
            0: begin c = 32'(cnt_w); w = wrap_w; mx = amax_w; mn = amin_w; end
            1: begin c = 32'(cnt_s); w = wrap_s; mx = amax_s; mn = amin_s; end
            2: begin c = 32'(cnt_p); w = wrap_p; mx = amax_p; mn = amin_p; end
            default: begin c = 32'(cnt_f); w = wrap_f; mx = amax_f; mn = amin_f; end
        endcase
    endtask

    task automatic check_all();
        logic [31:0] c;
        logic w, mx, mn;
        for (int i = 0; i < 4; i++) begin
            get(i, c, w, mx, mn);
            check("cnt", i, c, 32'(m_cnt[i]));
            check("wrap", i, 32'(w), 32'(m_wrap[i]));
            check("at_max", i, 32'(mx), 32'(m_cnt[i] == mods[i] - 1));
            check("at_min", i, 32'(mn), 32'(m_cnt[i] == 0));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_psc[i] = 0; m_wrap[i] = 0;
        end
    endtask

    // One clock edge of the counting rules, applied with plain integer arithmetic.
    task automatic model_edge();
        int v;
        for (int i = 0; i < 4; i++) begin
            m_wrap[i] = 0;
            v = int'(lv) & masks[i];
            if (clr) begin
                m_cnt[i] = 0; m_psc[i] = 0;
            end else if (load) begin
                m_cnt[i] = (v >= mods[i]) ? mods[i] - 1 : v;
                m_psc[i] = 0;
            end else if (en) begin
                if (m_psc[i] < pres[i] - 1) begin
                    m_psc[i]++;
                end else begin
                    m_psc[i] = 0;
                    if (up) begin
                        if (m_cnt[i] < mods[i] - 1) m_cnt[i]++;
                        else if (sats[i] == 0) begin m_cnt[i] = 0; m_wrap[i] = 1; end
                    end else begin
                        if (m_cnt[i] > 0) m_cnt[i]--;
                        else if (sats[i] == 0) begin m_cnt[i] = mods[i] - 1; m_wrap[i] = 1; end
                    end
                end
            end
        end
    endtask

    // Drive at the falling edge, model the rising edge, compare at the next falling edge.
    task automatic step(input logic c, input logic l, input logic [7:0] v, input logic e, input logic u);
        clr = c; load = l; lv = v; en = e; up = u;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Reset pulse between edges: outputs must clear before any clock arrives.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 8'd5,  1'b1, 1'b1, 0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'd12, 1'b0, 1'b1, 9, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'd7,  1'b1, 1'b1, 7, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 8, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 9, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 9, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 8, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 8, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'd0,  1'b0, 1'b0, 0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 9, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 9, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b1, 0, 1'b0};

        rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; lv = 8'd0;
        model_reset();
        #2 check_all();
        @(negedge clk);
        rst = 1'b0;

        // Count up from reset on the full-range instance.
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
            check("reset_count", 3, 32'(cnt_f), 32'(k));
        end

        // Vector table on the MOD=10 wrapping instance.
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].clr, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].up);
            check("vec_cnt", 0, 32'(cnt_w), 32'(vecs[i].exp_cnt));
            check("vec_wrap", 0, 32'(wrap_w), 32'(vecs[i].exp_wrap));
        end

        // Full up wrap 0..9 then 0, plus 8-bit range boundary.
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
        for (int k = 0; k < 11; k++) step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'd255, 1'b0, 1'b1);
        check("full_max", 3, 32'(amax_f), 32'd1);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        check("full_wrap", 3, 32'(wrap_f), 32'd1);

        // Saturate holds at both ends.
        step(1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        check("sat_low", 1, 32'(cnt_s), 32'd0);
        step(1'b0, 1'b1, 8'd9, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        check("sat_high", 1, 32'(cnt_s), 32'd9);

        // Prescale: pause mid-count keeps psc; load clears psc.
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        check("psc_resume", 2, 32'(cnt_p), 32'd1);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'd3, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        check("psc_load_hold", 2, 32'(cnt_p), 32'd3);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        check("psc_load_step", 2, 32'(cnt_p), 32'd4);

        // Async reset mid-run at cnt=7 with en held high.
        step(1'b0, 1'b1, 8'd7, 1'b0, 1'b1);
        en = 1'b1;
        async_reset();
        check("rst_mid", 0, 32'(cnt_w), 32'd0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            step(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
